operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode/operand-fetch stage of the multicycle core; sits directly upstream of the register file read ports and downstream of the instruction register.
- Drives register-file read addresses from the incoming instruction, latches the read data into A/B operand registers, generates the sign-extended immediate, and presents a registered decoded bundle to execute over a valid/ready handshake.
- Snoops the register-file write port to forward same-cycle writebacks.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate
NREGS, 32, architectural register count; index width is clog2(NREGS)=5

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of held entry and incoming instruction
in_valid  in  1  instruction/PC valid from fetch
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
ra1  out  5  regfile read address 1 = in_instr[19:15]
ra2  out  5  regfile read address 2 = in_instr[24:20]
rd1  in  XLEN  regfile read data 1 (combinational)
rd2  in  XLEN  regfile read data 2 (combinational)
wb_we  in  1  regfile write enable (snooped)
wb_wa  in  5  regfile write address (snooped)
wb_wd  in  XLEN  regfile write data (snooped)
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_a  out  XLEN  rs1 operand
out_b  out  XLEN  rs2 operand
out_imm  out  XLEN  sign-extended immediate
out_pc  out  XLEN  PC of held instruction
out_rd  out  5  destination register index
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n).
- Reset: FSM=EMPTY; out_valid=0; every registered output is 0. Reset asserted mid-transfer drops the held entry immediately.
- FSM, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Handshake and latency:
  - in_ready = (state==EMPTY) || out_ready.
  - Accept when in_valid && in_ready && !flush.
  - Latency is exactly 1 cycle: accept at edge N, bundle visible after edge N.
- Transitions:
  - EMPTY->FULL on accept.
  - FULL->FULL on pop (out_valid && out_ready) with simultaneous accept.
  - FULL->EMPTY on pop without accept.
  - FULL holds while out_ready=0; all outputs stay stable.
- ra1/ra2 are combinational from in_instr; both are 0 when in_valid=0.
- Operand capture on accept: out_a=rd1, out_b=rd2, modified by bypass (see Optional Feature). Index 0 always yields 0, regardless of rd1/rd2 or bypass.
- Immediate by opcode, sign-extended from instr[31]:
  - I (0000011, 0010011, 1100111)
  - S (0100011)
  - B (1100011, bit0=0)
  - U (0110111, 0010111; low 12 bits 0)
  - J (1101111, bit0=0)
  - any other opcode: 0.
- out_rd = instr[11:7] for every opcode; execute ignores it for S/B.
- flush:
  - Next state is EMPTY and out_valid=0 after the edge.
  - flush wins over a simultaneous accept or pop.
  - in_ready is unaffected.

Optional Feature:
- Macro OPFETCH_BYPASS_EN.
- Defined:
  - On accept, if wb_we && wb_wa!=0 && wb_wa==rs1 (or rs2), the captured operand is wb_wd instead of rd1 (or rd2).
  - While FULL and not popping, the same match against the held rs1/rs2 indices overwrites out_a/out_b with wb_wd.
- Undefined:
  - Operands come only from rd1/rd2 and are never refreshed while held.
  - The control sequencer guarantees no read-after-write within the window.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL;
  - enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - XLEN default.
- One natural sub-module: imm_gen (combinational, instr -> imm).
- FSM and bypass stay in operand_fetch.

Test Plan:
- Basic decode: regfile x1=0x10; in_instr=0xFFD08293 (addi x5,x1,-3), in_valid=1 -> ra1=1 the same cycle; next cycle out_valid=1, out_a=0x10, out_imm=0xFFFFFFFD, out_rd=5.
- Immediates: 0x0020A423 (sw x2,8(x1)) -> out_imm=0x8, ra2=2; 0x123451B7 (lui x3) -> out_imm=0x12345000.
- Back-pressure: FULL with out_ready=0 and in_valid=1 -> in_ready=0, outputs unchanged for 5 cycles; out_ready=1 -> next instruction loaded the following cycle.
- Bypass: accept rs1=1 with wb_we=1, wb_wa=1, wb_wd=0xDEAD, rd1=0x10 -> out_a=0xDEAD with OPFETCH_BYPASS_EN, 0x10 without; wb_wa=0, wb_wd=5 with rs1=0 -> out_a=0.
- flush asserted together with accept and pop -> out_valid=0 next cycle; the next clean accept works.
- rst_n low between edges while FULL -> out_valid=0 and out_a=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: major opcodes, immediate formats and
// the default datapath width used by the decode/operand-fetch stage.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    // Map a major opcode to its immediate format; R-type and unknown
    // opcodes carry no immediate.
    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR: t = IMM_I;
            OP_STORE:                   t = IMM_S;
            OP_BRANCH:                  t = IMM_B;
            OP_LUI, OP_AUIPC:           t = IMM_U;
            OP_JAL:                     t = IMM_J;
            default:                    t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the 32-bit immediate selected by the
// opcode and sign-extends it from instr[31] to XLEN.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    // Format-specific bit shuffle; anything without an immediate yields 0.
    always_comb begin
        imm32 = '0;
        case (imm_type_of(instr_i[6:0]))
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage. Drives register-file read addresses from the
// incoming instruction, captures operands, PC, immediate and decoded fields
// into a one-entry output register handed to execute over valid/ready.
// Optional macro OPFETCH_BYPASS_EN forwards snooped register-file writes into
// the captured operands, both at capture time and while the entry is held.
module operand_fetch
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic [$clog2(NREGS)-1:0] ra1,
    output logic [$clog2(NREGS)-1:0] ra2,
    input  logic [XLEN-1:0]          rd1,
    input  logic [XLEN-1:0]          rd2,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_wa,
    input  logic [XLEN-1:0]          wb_wd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_a,
    output logic [XLEN-1:0]          out_b,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_pc,
    output logic [4:0]               out_rd,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_funct7
);

    localparam int RW = $clog2(NREGS);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] imm_q, pc_q;
    logic [4:0]      rd_q;
    logic [6:0]      opcode_q, funct7_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] imm_w;
    logic [XLEN-1:0] cap_a, cap_b;
    logic [RW-1:0]   rs1, rs2;
    logic            accept, pop;

    assign rs1 = in_instr[15 +: RW];
    assign rs2 = in_instr[20 +: RW];

    assign ra1 = in_valid ? rs1 : '0;
    assign ra2 = in_valid ? rs2 : '0;

    assign out_valid = (state_q == FULL);
    assign in_ready  = (state_q == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm_w)
    );

`ifdef OPFETCH_BYPASS_EN
    logic [RW-1:0] rs1_q, rs2_q;
    logic          wb_hit;

    assign wb_hit = wb_we && (wb_wa != '0);
`else
    // Write port is only snooped for forwarding; keep it visibly consumed.
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_wa, wb_wd};
`endif

    // Operand values to capture on accept; x0 always reads as zero.
    always_comb begin
        cap_a = rd1;
        cap_b = rd2;
`ifdef OPFETCH_BYPASS_EN
        if (wb_hit && wb_wa == rs1) cap_a = wb_wd;
        if (wb_hit && wb_wa == rs2) cap_b = wb_wd;
`endif
        if (rs1 == '0) cap_a = '0;
        if (rs2 == '0) cap_b = '0;
    end

    // Held operands: load on accept, otherwise refresh from writeback while parked.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (accept) begin
            a_d = cap_a;
            b_d = cap_b;
        end
`ifdef OPFETCH_BYPASS_EN
        else if (state_q == FULL && !pop) begin
            if (wb_hit && wb_wa == rs1_q) a_d = wb_wd;
            if (wb_hit && wb_wa == rs2_q) b_d = wb_wd;
        end
`endif
    end

    // Next-state: flush squashes everything, then accept refills, pop drains.
    always_comb begin
        state_d = state_q;
        if (flush)       state_d = EMPTY;
        else if (accept) state_d = FULL;
        else if (pop)    state_d = EMPTY;
    end

    // State register and output bundle; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
`ifdef OPFETCH_BYPASS_EN
            rs1_q    <= '0;
            rs2_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            if (accept) begin
                imm_q    <= imm_w;
                pc_q     <= in_pc;
                rd_q     <= in_instr[11:7];
                opcode_q <= in_instr[6:0];
                funct3_q <= in_instr[14:12];
                funct7_q <= in_instr[31:25];
`ifdef OPFETCH_BYPASS_EN
                rs1_q    <= rs1;
                rs2_q    <= rs2;
`endif
            end
        end
    end

    assign out_a      = a_q;
    assign out_b      = b_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign out_rd     = rd_q;
    assign out_opcode = opcode_q;
    assign out_funct3 = funct3_q;
    assign out_funct7 = funct7_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: expected bundles are queued when the
// stage accepts and compared when execute takes them.
module tb_operand_fetch;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [4:0]      ra1, ra2;
    logic [XLEN-1:0] rd1, rd2;
    logic            wb_we = 1'b0;
    logic [4:0]      wb_wa = '0;
    logic [XLEN-1:0] wb_wd = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_a, out_b, out_imm, out_pc;
    logic [4:0]      out_rd;
    logic [6:0]      out_opcode, out_funct7;
    logic [2:0]      out_funct3;

    always #5 clk = ~clk;

    logic [XLEN-1:0] regs [32];
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    operand_fetch #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7)
    );

    typedef struct packed {
        logic [31:0] a, b, imm, pc;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        exp_valid = 1'b0;
    logic        acc_last = 1'b0;
    logic [31:0] imm_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Model of the handshake and operand capture, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_valid = 1'b0;
            acc_last  = 1'b0;
            sb.delete();
        end else begin
            logic acc, pop_e;
            exp_t e;
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, !exp_valid || out_ready);
            chk("ra1", ra1, in_valid ? in_instr[19:15] : 5'd0);
            chk("ra2", ra2, in_valid ? in_instr[24:20] : 5'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_imm", out_imm, e.imm);
                    chk("out_pc", out_pc, e.pc);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_opcode", out_opcode, e.op);
                    chk("out_funct3", out_funct3, e.f3);
                    chk("out_funct7", out_funct7, e.f7);
                end
            end
`ifdef OPFETCH_BYPASS_EN
            if (exp_valid && !out_ready && sb.size() > 0 && wb_we && wb_wa != 0) begin
                if (wb_wa == sb[0].rs1) sb[0].a = wb_wd;
                if (wb_wa == sb[0].rs2) sb[0].b = wb_wd;
            end
`endif
            acc   = in_valid && (!exp_valid || out_ready) && !flush;
            pop_e = exp_valid && out_ready;
            if (acc) begin
                e.rs1 = in_instr[19:15];
                e.rs2 = in_instr[24:20];
                e.a   = regs[e.rs1];
                e.b   = regs[e.rs2];
`ifdef OPFETCH_BYPASS_EN
                if (wb_we && wb_wa != 0 && wb_wa == e.rs1) e.a = wb_wd;
                if (wb_we && wb_wa != 0 && wb_wa == e.rs2) e.b = wb_wd;
`endif
                if (e.rs1 == 0) e.a = '0;
                if (e.rs2 == 0) e.b = '0;
                e.imm = imm_exp;
                e.pc  = in_pc;
                e.rd  = in_instr[11:7];
                e.op  = in_instr[6:0];
                e.f3  = in_instr[14:12];
                e.f7  = in_instr[31:25];
                sb.push_back(e);
            end
            acc_last  = acc;
            exp_valid = flush ? 1'b0 : acc ? 1'b1 : pop_e ? 1'b0 : exp_valid;
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        imm_exp  = imm;
    endtask

    task automatic wait_acc();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_last) break;
        end
        if (!acc_last) chk("accept_timeout", acc_last, 1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm);
        drive(instr, pc, imm);
        wait_acc();
    endtask

    logic [31:0] tbl_instr [11];
    logic [31:0] tbl_imm   [11];

    initial begin
        tbl_instr[0]  = 32'h0020A423; tbl_imm[0]  = 32'h00000008; // sw x2,8(x1)
        tbl_instr[1]  = 32'h123451B7; tbl_imm[1]  = 32'h12345000; // lui x3
        tbl_instr[2]  = 32'hFE208CE3; tbl_imm[2]  = 32'hFFFFFFF8; // beq -8
        tbl_instr[3]  = 32'h001000EF; tbl_imm[3]  = 32'h00000800; // jal +2048
        tbl_instr[4]  = 32'hFFFFF06F; tbl_imm[4]  = 32'hFFFFFFFE; // jal -2
        tbl_instr[5]  = 32'hFE20AE23; tbl_imm[5]  = 32'hFFFFFFFC; // sw -4
        tbl_instr[6]  = 32'hFFFFF217; tbl_imm[6]  = 32'hFFFFF000; // auipc
        tbl_instr[7]  = 32'h40208333; tbl_imm[7]  = 32'h00000000; // sub
        tbl_instr[8]  = 32'h00C08067; tbl_imm[8]  = 32'h0000000C; // jalr 12
        tbl_instr[9]  = 32'hFFC0A083; tbl_imm[9]  = 32'hFFFFFFFC; // lw -4
        tbl_instr[10] = 32'hFFF0000F; tbl_imm[10] = 32'h00000000; // other opcode

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'h11 * i;
        regs[0] = 32'hBAD00000;
        regs[1] = 32'h00000010;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_opcode", out_opcode, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic decode: addi x5,x1,-3
        drive(32'hFFD08293, 32'h100, 32'hFFFFFFFD);
        #1;
        chk("basic_ra1", ra1, 1);
        wait_acc();
        chk("basic_valid", out_valid, 1);
        chk("basic_a", out_a, 32'h10);
        chk("basic_imm", out_imm, 32'hFFFFFFFD);
        chk("basic_rd", out_rd, 5);

        // Back-to-back immediate formats
        for (int i = 0; i < 11; i++) issue(tbl_instr[i], 32'h200 + 4 * i, tbl_imm[i]);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: held entry stays stable, next one waits
        out_ready = 1'b0;
        issue(32'h0020A423, 32'h300, 32'h8);
        drive(32'h123451B7, 32'h304, 32'h12345000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_imm", out_imm, sb[0].imm);
            chk("bp_pc", out_pc, sb[0].pc);
            chk("bp_a", out_a, sb[0].a);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_acc();
        chk("bp_next_pc", out_pc, 32'h304);
        repeat (2) @(posedge clk);
        #1;

        // Bypass on capture, and x0 never forwarded
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'hDEAD;
        issue(32'hFFD08293, 32'h400, 32'hFFFFFFFD);
`ifdef OPFETCH_BYPASS_EN
        chk("byp_a", out_a, 32'hDEAD);
`else
        chk("byp_a", out_a, 32'h10);
`endif
        wb_wa = 5'd0; wb_wd = 32'h5;
        issue(32'h00500393, 32'h404, 32'h5);
        chk("byp_x0_a", out_a, 0);
        wb_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Writeback while parked: add x6,x1,x2
        out_ready = 1'b0;
        issue(32'h00208333, 32'h500, 32'h0);
        wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'hBEEF;
        @(posedge clk); #1;
        wb_we = 1'b0;
`ifdef OPFETCH_BYPASS_EN
        chk("held_b", out_b, 32'hBEEF);
`else
        chk("held_b", out_b, regs[2]);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush together with accept and pop, then a clean accept
        issue(32'h0020A423, 32'h600, 32'h8);
        drive(32'h123451B7, 32'h604, 32'h12345000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        wait_acc();
        chk("flush_next_pc", out_pc, 32'h604);
        chk("flush_next_imm", out_imm, 32'h12345000);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        issue(32'hFFD08293, 32'h700, 32'hFFFFFFFD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_a", out_a, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        issue(32'h0020A423, 32'h800, 32'h8);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
